uart_fifo: RTL and testbench

Parametrised UART core: serial receiver and transmitter, each buffered by its own synchronous FIFO, with a byte-wide valid/ready host interface. It is the next generation of the board-level UART top. It adds configurable frame format (data bits, parity, stop bits), configurable FIFO depth, error reporting, and a hardware echo (loopback) mode. It sits between the board rx/tx pins and any on-chip byte consumer or producer.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_fifo_if.sv | 15 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_fifo.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: parity encodings, FSM states and
// the clocks-per-bit helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_PUSH
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Byte-wide host handshake of the UART core: TX write side and RX
// first-word fall-through read side.
interface uart_fifo_if;

    logic       i_wr;
    logic [7:0] i_data;
    logic       o_full;
    logic       i_rd;
    logic [7:0] o_data;
    logic       o_rdy;

    modport master (output i_wr, i_data, i_rd, input o_full, o_data, o_rdy);
    modport slave  (input i_wr, i_data, i_rd, output o_full, o_data, o_rdy);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with registered full/empty flags.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Head reads as zero while empty so the output is defined straight out of reset.
    assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_fifo.sv
// UART core: oversampling receiver and transmitter, each buffered by a FIFO,
// with configurable frame format, sticky error flags and hardware echo.
module uart_fifo import uart_pkg::*; #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    output logic        o_tx,
    uart_fifo_if.slave  host,
    input  logic        i_loopback,
    input  logic        i_clr,
    output logic        o_frm_err,
    output logic        o_par_err,
    output logic        o_ovf
);

    localparam int          DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int          CW        = $clog2(DIV);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF    = CW'(DIV / 2 - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [7:0]  DMASK     = 8'((1 << DATA_BITS) - 1);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [2:0]    rx_sync_q;
    logic          rx_s, rx_fall;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_par_q, rx_par_d, rx_stop_q, rx_stop_d;
    logic          rx_push, rx_par_bad;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic          tx_stop_q, tx_stop_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d, tx_par, tx_pop;

    logic          frm_err_q, frm_err_d, par_err_q, par_err_d, ovf_q, ovf_d;
    logic          rx_to_rx, rx_to_tx, rx_drop, tx_push;
    logic [7:0]    tx_wdata, tx_head, rx_head;
    logic          tx_full, tx_empty, rx_full, rx_empty;

    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_s;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_stop_d  = rx_stop_q;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_sh_d    = '0;
                end
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == LAST) begin
                rx_cnt_d          = '0;
                rx_sh_d[rx_bit_q] = rx_s;
                rx_bit_d          = rx_bit_q + 3'd1;
                if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_par_d   = rx_s;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == LAST) begin
                rx_cnt_d   = '0;
                rx_stop_d  = rx_s;
                rx_state_d = RX_PUSH;
            end
            RX_PUSH: begin
                rx_push    = 1'b1;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_par_bad = (PARITY == PAR_EVEN) ? (^rx_sh_q ^ rx_par_q) :
                        (PARITY == PAR_ODD)  ? ~(^rx_sh_q ^ rx_par_q) : 1'b0;
    assign tx_par     = (PARITY == PAR_ODD) ? ~(^tx_sh_q) : ^tx_sh_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_cnt_q == LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_sh_q[0];
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q != BIT_LAST) begin
                    tx_d = tx_sh_q[tx_bit_q + 3'd1];
                end else if (PARITY != PAR_NONE) begin
                    tx_d       = tx_par;
                    tx_state_d = TX_PARITY;
                end else begin
                    tx_d       = 1'b1;
                    tx_stop_d  = 1'b0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_PARITY: if (tx_cnt_q == LAST) begin
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
                tx_stop_d  = 1'b0;
                tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt_q == LAST) begin
                tx_cnt_d = '0;
                if (tx_stop_q != STOP_LAST) begin
                    tx_stop_d = 1'b1;
                end else if (!tx_empty) begin
                    // Chain straight into the next start bit with no idle gap.
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end else begin
                    tx_d       = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // In echo mode a received byte takes the TX FIFO write port from the host.
    assign rx_to_tx  = rx_push & i_loopback;
    assign rx_to_rx  = rx_push & ~i_loopback;
    assign tx_push   = rx_to_tx | host.i_wr;
    assign tx_wdata  = rx_to_tx ? rx_sh_q : (host.i_data & DMASK);
    assign rx_drop   = (rx_to_rx & rx_full & ~host.i_rd) | (rx_to_tx & tx_full & ~tx_pop);

    assign frm_err_d = (frm_err_q & ~i_clr) | (rx_push & ~rx_stop_q);
    assign par_err_d = (par_err_q & ~i_clr) | (rx_push & rx_par_bad);
    assign ovf_d     = (ovf_q & ~i_clr) | rx_drop;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 3'b111;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
            rx_stop_q  <= 1'b1;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[1:0], i_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_stop_q  <= rx_stop_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            frm_err_q  <= frm_err_d;
            par_err_q  <= par_err_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i(i_clk), .rst_ni(rst_n), .push_i(tx_push), .data_i(tx_wdata),
        .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i(i_clk), .rst_ni(rst_n), .push_i(rx_to_rx), .data_i(rx_sh_q),
        .pop_i(host.i_rd), .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign o_tx        = tx_q;
    assign host.o_full = tx_full;
    assign host.o_rdy  = ~rx_empty;
    assign host.o_data = rx_head;
    assign o_frm_err   = frm_err_q;
    assign o_par_err   = par_err_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: instance A is 8N1 with 4-entry FIFOs, instance B is 8E1.
// Expected RX/TX bytes are queued at stimulus time and popped by monitors.
module tb_uart_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic tx_a, tx_b;
    logic lb_a = 1'b0, lb_b = 1'b0;
    logic clr_a = 1'b0, clr_b = 1'b0;
    logic frm_a, par_a, ovf_a, frm_b, par_b, ovf_b;

    int checks = 0;
    int failures = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic rd_en = 1'b1;
    logic tx_mon_en = 1'b1;

    uart_fifo_if hif_a();
    uart_fifo_if hif_b();

    always #5 clk = ~clk;

    uart_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_tx(tx_a), .host(hif_a),
        .i_loopback(lb_a), .i_clr(clr_a), .o_frm_err(frm_a), .o_par_err(par_a), .o_ovf(ovf_a)
    );

    uart_fifo #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_tx(tx_b), .host(hif_b),
        .i_loopback(lb_b), .i_clr(clr_b), .o_frm_err(frm_b), .o_par_err(par_b), .o_ovf(ovf_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else       rx_a = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel_b, input logic [7:0] b, input bit use_par,
                        input logic pbit, input logic stop);
        drive_bit(sel_b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel_b, b[i]);
        if (use_par) drive_bit(sel_b, pbit);
        drive_bit(sel_b, stop);
        if (sel_b) rx_b = 1'b1;
        else       rx_a = 1'b1;
    endtask

    task automatic host_wr_a(input logic [7:0] b);
        hif_a.i_wr   = 1'b1;
        hif_a.i_data = b;
        step();
        hif_a.i_wr   = 1'b0;
    endtask

    task automatic wait_rxq(input int budget);
        int n = 0;
        while (rxq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("rx_queue_drained", rxq.size(), 0);
    endtask

    task automatic wait_txq(input int budget);
        int n = 0;
        while (txq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("tx_queue_drained", txq.size(), 0);
    endtask

    // RX monitor: reads A whenever it presents a byte and reading is enabled.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rd_en && hif_a.o_rdy === 1'b1) begin
                if (rxq.size() == 0) begin
                    chk("rx_unexpected_byte", hif_a.o_data, 32'hFFFF_FFFF);
                end else begin
                    exp = rxq.pop_front();
                    chk("rx_byte", hif_a.o_data, exp);
                end
                hif_a.i_rd = 1'b1;
                @(posedge clk);
                #1;
                hif_a.i_rd = 1'b0;
            end
        end
    end

    // TX monitor: decodes frames on A's line at mid-bit.
    initial begin
        logic [7:0] b;
        logic       s;
        forever begin
            @(negedge clk);
            if (tx_a === 1'b0 && tx_mon_en) begin
                repeat (8) @(negedge clk);
                chk("tx_mon_start", tx_a, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx_a;
                end
                repeat (16) @(negedge clk);
                s = tx_a;
                chk("tx_mon_stop", s, 1);
                if (txq.size() == 0) chk("tx_unexpected_frame", b, 32'hFFFF_FFFF);
                else                 chk("tx_mon_byte", b, txq.pop_front());
            end
        end
    end

    initial begin
        logic       smp [170];
        logic [9:0] line;
        int         errs;
        logic       seen;

        hif_a.i_wr = 1'b0; hif_a.i_data = '0; hif_a.i_rd = 1'b0;
        hif_b.i_wr = 1'b0; hif_b.i_data = '0; hif_b.i_rd = 1'b0;
        repeat (3) step();
        chk("rst_tx", tx_a, 1);
        chk("rst_full", hif_a.o_full, 0);
        chk("rst_rdy", hif_a.o_rdy, 0);
        chk("rst_data", hif_a.o_data, 0);
        chk("rst_flags", {frm_a, par_a, ovf_a}, 0);
        chk("rst_flags_b", {frm_b, par_b, ovf_b}, 0);
        rst_n = 1'b1;
        repeat (4) step();

        // Host transmit of 0xA5 with exact line timing.
        line = 10'b1101001010;
        txq.push_back(8'hA5);
        host_wr_a(8'hA5);
        seen = 1'b0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            smp[i] = tx_a;
            if (hif_a.o_full !== 1'b0) seen = 1'b1;
        end
        chk("tx_idle_during_pop", smp[0], 1);
        chk("tx_start_next_cycle", smp[1], 0);
        for (int k = 0; k < 10; k++) begin
            errs = 0;
            for (int j = 0; j < 16; j++) if (smp[1 + 16*k + j] !== line[k]) errs++;
            chk($sformatf("tx_bit%0d_bad_cycles", k), errs, 0);
        end
        chk("tx_idle_after_stop", smp[161], 1);
        chk("tx_full_stays_low", seen, 0);
        step();
        wait_txq(50);

        // Receive 0x3C cleanly.
        rxq.push_back(8'h3C);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_rxq(50);
        chk("rx_rdy_after_read", hif_a.o_rdy, 0);
        chk("rx_clean_flags", {frm_a, par_a, ovf_a}, 0);

        // One-cycle glitch must not produce a byte.
        rx_a = 1'b0;
        step();
        rx_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hif_a.o_rdy !== 1'b0) seen = 1'b1;
        end
        chk("glitch_no_push", seen, 0);

        // Five frames into a 4-deep RX FIFO without reading.
        rd_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rxq.push_back(8'(i * 8'h11));
            send(1'b0, 8'(i * 8'h11), 1'b0, 1'b0, 1'b1);
        end
        repeat (4) step();
        chk("ovf_not_yet", ovf_a, 0);
        chk("ovf_rdy_full", hif_a.o_rdy, 1);
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (4) step();
        chk("ovf_set", ovf_a, 1);
        chk("ovf_head_oldest", hif_a.o_data, 8'h11);
        rd_en = 1'b1;
        wait_rxq(100);
        step();
        chk("ovf_drained_rdy", hif_a.o_rdy, 0);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("ovf_cleared", ovf_a, 0);

        // Even parity: 0x07 with a wrong parity bit, then a low stop bit.
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (2) step();
        chk("par_byte_rdy", hif_b.o_rdy, 1);
        chk("par_byte_data", hif_b.o_data, 8'h07);
        chk("par_err_set", par_b, 1);
        chk("par_no_frm", frm_b, 0);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        chk("par_err_cleared", par_b, 0);
        hif_b.i_rd = 1'b1;
        step();
        hif_b.i_rd = 1'b0;
        chk("par_rdy_after_read", hif_b.o_rdy, 0);
        send(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        repeat (2) step();
        chk("frm_err_set", frm_b, 1);
        chk("frm_par_ok", par_b, 0);
        chk("frm_byte_data", hif_b.o_data, 8'h12);

        // Loopback echo of 0x41.
        lb_a = 1'b1;
        txq.push_back(8'h41);
        seen = 1'b0;
        send(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
        wait_txq(300);
        lb_a = 1'b0;
        chk("loop_rx_fifo_empty", hif_a.o_rdy, 0);

        // Reset in the middle of a transmit frame.
        tx_mon_en = 1'b0;
        host_wr_a(8'h00);
        repeat (40) step();
        chk("tx_mid_frame_low", tx_a, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("tx_async_reset", tx_a, 1);
        chk("reset_full", hif_a.o_full, 0);
        chk("reset_rdy", hif_a.o_rdy, 0);
        step();
        rst_n = 1'b1;
        repeat (30) step();
        chk("tx_idle_after_reset", tx_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
